pipe_ctrl_unit: RTL and testbench

Centralised, parametrised pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It replaces the separate hazard-detection and forwarding units and adds three things:
- a data-memory wait freeze;
- a halt-drain state machine;
- optional forwarding-disabled (stall-only) mode.

It also provides saturating stall and flush performance counters. It sits beside the datapath and drives every pipeline-register enable, flush, bubble and forwarding-mux select.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_unit_sat_counter.sv | 21 ++
 rtl/pipe_ctrl_unit.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller.
//   fwd_sel_t    : EX operand mux select (regfile / WB / MEM)
//   ctrl_state_t : controller state (run, two drain cycles, halted)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN0,
    DRAIN1,
    HALTED
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall / flush performance counters.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   inc        : add one this cycle unless already at all-ones
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Centralised pipeline controller for the 5-stage RV32 core: hazard stall,
// branch flush, data-memory freeze, halt drain, EX forwarding selects and
// saturating stall/flush counters.
//   clk, reset                 : clock, synchronous active-high reset
//   id_rs1/2, id_use_rs1/2     : ID source registers and their use bits
//   ex_rs1/2                   : sources held in ID/EX (forwarding compare)
//   ex_/mem_/wb_rd, *_regwrite : per-stage destination and write enable
//   ex_memread, br_taken       : load in EX, redirect resolved in EX
//   ex_halt, dmem_busy         : halt in EX, data memory not ready
//   pc_en..memwb_en            : pipeline register enables
//   ifid_flush, idex_bubble    : NOP insertion into IF/ID and ID/EX
//   fwd_a, fwd_b               : EX operand mux selects
//   halted                     : pipe fully drained after halt
//   stall_cnt, flush_cnt       : saturating performance counters
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rs1,
  input  logic [RF_ADDR_W-1:0] ex_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic [RF_ADDR_W-1:0] mem_rd,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic                 ex_regwrite,
  input  logic                 mem_regwrite,
  input  logic                 wb_regwrite,
  input  logic                 ex_memread,
  input  logic                 br_taken,
  input  logic                 ex_halt,
  input  logic                 dmem_busy,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  ctrl_state_t state, state_next;
  logic        stall_inc, flush_inc;
  logic        hazard;

  function automatic logic rs_hit(input logic [RF_ADDR_W-1:0] rs,
                                  input logic                 use_rs,
                                  input logic [RF_ADDR_W-1:0] rd,
                                  input logic                 we);
    return use_rs && (rs != '0) && (rs == rd) && we;
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic [RF_ADDR_W-1:0] rs);
    if (mem_regwrite && (mem_rd != '0) && (rs == mem_rd))
      return FWD_MEM;
    else if (wb_regwrite && (wb_rd != '0) && (rs == wb_rd))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Without forwarding every in-flight producer blocks ID, because the
  // regfile is not write-through; with forwarding only a load in EX does.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = rs_hit(id_rs1, id_use_rs1, ex_rd, ex_regwrite && ex_memread) ||
               rs_hit(id_rs2, id_use_rs2, ex_rd, ex_regwrite && ex_memread);
    end else begin
      hazard = rs_hit(id_rs1, id_use_rs1, ex_rd,  ex_regwrite)  ||
               rs_hit(id_rs1, id_use_rs1, mem_rd, mem_regwrite) ||
               rs_hit(id_rs1, id_use_rs1, wb_rd,  wb_regwrite)  ||
               rs_hit(id_rs2, id_use_rs2, ex_rd,  ex_regwrite)  ||
               rs_hit(id_rs2, id_use_rs2, mem_rd, mem_regwrite) ||
               rs_hit(id_rs2, id_use_rs2, wb_rd,  wb_regwrite);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;

    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_next  = RUN;
    end else begin
      if (FWD_EN != 0) begin
        fwd_a = fwd_pick(ex_rs1);
        fwd_b = fwd_pick(ex_rs2);
      end
      unique case (state)
        RUN: begin
          if (dmem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else if (ex_halt) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = DRAIN0;
          end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end
        end
        DRAIN0, DRAIN1: begin
          if (dmem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = (state == DRAIN0) ? DRAIN1 : HALTED;
          end
        end
        HALTED: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
        default: state_next = RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

  localparam int CMAX = 65535;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, mem_regwrite, wb_regwrite;
  logic       ex_memread, br_taken, ex_halt, dmem_busy;

  // suffix _1: forwarding build, _0: stall-only build
  logic        pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1;
  logic        ifid_flush_1, idex_bubble_1, halted_1;
  logic [1:0]  fwd_a_1, fwd_b_1;
  logic [15:0] stall_cnt_1, flush_cnt_1;
  logic        pc_en_0, ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0;
  logic        ifid_flush_0, idex_bubble_0, halted_0;
  logic [1:0]  fwd_a_0, fwd_b_0;
  logic [15:0] stall_cnt_0, flush_cnt_0;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state per build: -1 running, 2/1 drain cycles left, 0 halted
  int drain_left[2];
  int scnt[2];
  int fcnt[2];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.RF_ADDR_W(5), .FWD_EN(1), .CNT_W(16)) dut_fwd (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .br_taken(br_taken), .ex_halt(ex_halt), .dmem_busy(dmem_busy),
    .pc_en(pc_en_1), .ifid_en(ifid_en_1), .idex_en(idex_en_1), .exmem_en(exmem_en_1),
    .memwb_en(memwb_en_1), .ifid_flush(ifid_flush_1), .idex_bubble(idex_bubble_1),
    .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .halted(halted_1),
    .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
  );

  pipe_ctrl_unit #(.RF_ADDR_W(5), .FWD_EN(0), .CNT_W(16)) dut_nofwd (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .br_taken(br_taken), .ex_halt(ex_halt), .dmem_busy(dmem_busy),
    .pc_en(pc_en_0), .ifid_en(ifid_en_0), .idex_en(idex_en_0), .exmem_en(exmem_en_0),
    .memwb_en(memwb_en_0), .ifid_flush(ifid_flush_0), .idex_bubble(idex_bubble_0),
    .fwd_a(fwd_a_0), .fwd_b(fwd_b_0), .halted(halted_0),
    .stall_cnt(stall_cnt_0), .flush_cnt(flush_cnt_0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_comb(input int k);
    if (k == 0)
      return {pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1,
              ifid_flush_1, idex_bubble_1, fwd_a_1, fwd_b_1};
    return {pc_en_0, ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0,
            ifid_flush_0, idex_bubble_0, fwd_a_0, fwd_b_0};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && rs == mem_rd) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && rs == wb_rd) return 2'b01;
    return 2'b00;
  endfunction

  // k=0: only a load in EX blocks; k=1: any pending writer of a live source
  function automatic bit ref_hazard(input int k);
    logic [4:0] src[2];
    bit         live[2];
    logic [4:0] prd[3];
    bit         pwe[3];
    src[0] = id_rs1; live[0] = id_use_rs1 && id_rs1 != 0;
    src[1] = id_rs2; live[1] = id_use_rs2 && id_rs2 != 0;
    prd[0] = ex_rd;  pwe[0] = ex_regwrite && (k == 1 || ex_memread);
    prd[1] = mem_rd; pwe[1] = (k == 1) && mem_regwrite;
    prd[2] = wb_rd;  pwe[2] = (k == 1) && wb_regwrite;
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 3; p++)
        if (live[s] && pwe[p] && src[s] == prd[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input int k, output logic [10:0] e, output int nd,
                       output bit si, output bit fi);
    bit pc, ifd, idx, exm, mwb, fl, bb;
    logic [1:0] fa, fb;
    pc = 1; ifd = 1; idx = 1; exm = 1; mwb = 1; fl = 0; bb = 0;
    fa = 2'b00; fb = 2'b00;
    nd = drain_left[k]; si = 0; fi = 0;
    if (!reset && k == 0) begin
      fa = ref_fwd(ex_rs1);
      fb = ref_fwd(ex_rs2);
    end
    if (reset) begin
      fl = 1; bb = 1; nd = -1;
    end else if (drain_left[k] == 0 || dmem_busy) begin
      {pc, ifd, idx, exm, mwb} = '0;
    end else if (drain_left[k] > 0) begin
      pc = 0; fl = 1; bb = 1; nd = drain_left[k] - 1;
    end else if (ex_halt) begin
      pc = 0; fl = 1; bb = 1; nd = 2;
    end else if (br_taken) begin
      fl = 1; bb = 1; fi = 1;
    end else if (ref_hazard(k)) begin
      pc = 0; ifd = 0; bb = 1; si = 1;
    end
    e = {pc, ifd, idx, exm, mwb, fl, bb, fa, fb};
  endtask

  // Inputs are set before the call; compares this cycle, then clocks.
  task automatic step();
    logic [10:0] e;
    int nd[2];
    bit si[2], fi[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      model(k, e, nd[k], si[k], fi[k]);
      check(k == 0 ? "ctrl_fwd" : "ctrl_nofwd", 32'(obs_comb(k)), 32'(e));
      check(k == 0 ? "halted_fwd" : "halted_nofwd",
            32'(k == 0 ? halted_1 : halted_0), 32'(drain_left[k] == 0));
      check(k == 0 ? "stall_cnt_fwd" : "stall_cnt_nofwd",
            32'(k == 0 ? stall_cnt_1 : stall_cnt_0), 32'(scnt[k]));
      check(k == 0 ? "flush_cnt_fwd" : "flush_cnt_nofwd",
            32'(k == 0 ? flush_cnt_1 : flush_cnt_0), 32'(fcnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      drain_left[k] = nd[k];
      if (reset) begin
        scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (si[k] && scnt[k] < CMAX) scnt[k]++;
        if (fi[k] && fcnt[k] < CMAX) fcnt[k]++;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
    ex_memread = 0; br_taken = 0; ex_halt = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      drain_left[k] = -1; scnt[k] = 0; fcnt[k] = 0;
    end

    // reset output values
    #1;
    check("reset_ctrl", 32'(obs_comb(0)), 32'(11'b1111111_00_00));
    step();
    reset = 0;
    check("reset_stall_cnt", 32'(stall_cnt_1), 32'd0);

    // load-use with forwarding: single stall cycle
    set_load_use();
    #1;
    check("loaduse_pc_ifid_bubble", 32'({pc_en_1, ifid_en_1, idex_bubble_1}), 32'(3'b001));
    step();
    clear_inputs();
    step();
    check("loaduse_stall_cnt", 32'(stall_cnt_1), 32'd1);

    // forwarding priority
    ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
    #1; check("fwd_mem_prio", 32'(fwd_a_1), 32'(2'b10));
    step();
    mem_rd = 0;
    #1; check("fwd_wb", 32'(fwd_a_1), 32'(2'b01));
    step();
    ex_rs1 = 0;
    #1; check("fwd_x0", 32'(fwd_a_1), 32'(2'b00));
    step();
    clear_inputs();

    // branch wins over load-use
    set_load_use();
    br_taken = 1;
    #1;
    check("br_vs_loaduse", 32'({pc_en_1, ifid_flush_1, idex_bubble_1}), 32'(3'b111));
    step();
    clear_inputs();
    step();
    check("br_flush_cnt", 32'(flush_cnt_1), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt_1), 32'd1);

    // dmem_busy freeze over load-use, then the stall
    set_load_use();
    dmem_busy = 1;
    repeat (3) begin
      #1;
      check("freeze_enables", 32'({pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1}), 32'd0);
      step();
    end
    check("freeze_stall_cnt", 32'(stall_cnt_1), 32'd1);
    dmem_busy = 0;
    step();
    clear_inputs();
    step();
    check("after_freeze_stall_cnt", 32'(stall_cnt_1), 32'd2);

    // halt drain
    ex_halt = 1;
    step();
    ex_halt = 0;
    br_taken = 1;
    step();
    step();
    br_taken = 0;
    check("halted_3rd_edge", 32'(halted_1), 32'd1);
    check("halted_enables", 32'({pc_en_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1}), 32'd0);
    dmem_busy = 1;
    step();
    do_reset();
    check("halt_reset_halted", 32'(halted_1), 32'd0);
    check("halt_reset_cnt", 32'(flush_cnt_1), 32'd0);

    // stall-only build: producer of x7 walking EX -> MEM -> WB
    id_rs2 = 7; id_use_rs2 = 1; ex_rs2 = 7;
    ex_rd = 7; ex_regwrite = 1;
    step();
    ex_rd = 0; ex_regwrite = 0; mem_rd = 7; mem_regwrite = 1;
    #1; check("nofwd_fwd_b", 32'(fwd_b_0), 32'd0);
    step();
    mem_rd = 0; mem_regwrite = 0; wb_rd = 7; wb_regwrite = 1;
    #1; check("nofwd_fwd_b_wb", 32'(fwd_b_0), 32'd0);
    step();
    wb_rd = 0; wb_regwrite = 0;
    step();
    check("nofwd_stall_cnt", 32'(stall_cnt_0), 32'd3);
    check("fwd_build_no_stall", 32'(stall_cnt_1), 32'd0);
    clear_inputs();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_rs1       = 5'($urandom_range(0, 3));
      ex_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom);
      mem_regwrite = 1'($urandom);
      wb_regwrite  = 1'($urandom);
      ex_memread   = 1'($urandom);
      br_taken     = ($urandom_range(0, 5) == 0);
      ex_halt      = ($urandom_range(0, 39) == 0);
      dmem_busy    = ($urandom_range(0, 4) == 0);
      step();
    end

    // counter saturation: 2^16+5 stall cycles
    do_reset();
    set_load_use();
    repeat (65536 + 5) step();
    check("sat_stall_fwd", 32'(stall_cnt_1), 32'h0000FFFF);
    check("sat_stall_nofwd", 32'(stall_cnt_0), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
